// File: rtl/typing_stats.sv
`default_nettype none
// ============================================================================
// Module   : typing_stats
// Purpose  : Per-race statistics engine feeding the VGA display top. Counts
//            keystrokes, elapsed time and word progress, and computes wpm,
//            accuracy and completion percent. All three share one restoring
//            divider (18-bit numerator / 16-bit divisor, 1 load + 18 cycles).
// Ports    : clk, rst (async, active-low)
//            start, key_valid, key_correct, key_space  - game FSM controls
//            passage_len[9:0], word_count[4:0]        - sampled on start
//            percent, wpm, acc [9:0]                   - computed stats
//            correct, tot [4:0]                        - word progress
//            times[14:0]                               - race time, 0.1 s
//            running, done                             - race status
// Config   : define STATS_ROUND_EN for round-to-nearest division
//            (numerator += divisor>>1); default is truncating division.
// Revision : 1.0 - initial release
// ============================================================================
module typing_stats #(
    parameter int CLK_HZ   = 100000000,
    parameter int TICK_DIV = CLK_HZ / 10,
    parameter int WPM_MAX  = 999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        key_valid,
    input  logic        key_correct,
    input  logic        key_space,
    input  logic [9:0]  passage_len,
    input  logic [4:0]  word_count,
    output logic [9:0]  percent,
    output logic [9:0]  wpm,
    output logic [9:0]  acc,
    output logic [4:0]  correct,
    output logic [4:0]  tot,
    output logic [14:0] times,
    output logic        running,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [1:0]    OP_WPM    = 2'd0;
    localparam logic [1:0]    OP_ACC    = 2'd1;
    localparam logic [1:0]    OP_PCT    = 2'd2;
    localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

`ifdef STATS_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    state_t         r_state, w_state_nx;
    logic [9:0]     r_len, r_pos, r_snap_pos;
    logic [15:0]    r_good, r_all, r_snap_good, r_snap_all;
    logic [14:0]    r_snap_times;
    logic [4:0]     r_words;
    logic [PW-1:0]  r_presc;
    logic           r_pend, r_busy, r_load, r_final;
    logic [1:0]     r_op;
    logic [4:0]     r_cnt;
    logic [17:0]    r_num;
    logic [15:0]    r_rem, r_den;

    logic           w_run, w_tick, w_key, w_trig, w_launch, w_do_load;
    logic [1:0]     w_ld_op, w_wr_op;
    logic [15:0]    w_src_good, w_src_all, w_ld_den, w_rem_nx;
    logic [14:0]    w_src_times;
    logic [9:0]     w_src_pos;
    logic [17:0]    w_ld_num, w_ld_num_adj, w_quot, w_wr_val;
    logic [16:0]    w_shift;
    logic           w_ge, w_den_zero, w_iter_last, w_wr_en, w_seq_end;

    assign w_run   = (r_state == ST_RUN);
    assign w_tick  = w_run && !start && (r_presc == TICK_LAST);
    assign w_key   = w_run && !start && key_valid;
    // A tick, or the last passage char landing, requests a recompute.
    assign w_trig  = !start && (w_tick || (w_run && (r_pos == r_len)));
    // Launch one cycle after the request so counters have settled.
    assign w_launch  = r_pend && !r_busy && !start &&
                       ((r_state == ST_RUN) || (r_state == ST_FIN));
    assign w_do_load = w_launch || (r_busy && r_load);

    // The first op loads straight from live counters; later ops use the
    // snapshot captured at launch so mid-sequence keys do not leak in.
    assign w_ld_op     = w_launch ? OP_WPM  : r_op;
    assign w_src_good  = w_launch ? r_good  : r_snap_good;
    assign w_src_all   = w_launch ? r_all   : r_snap_all;
    assign w_src_times = w_launch ? times   : r_snap_times;
    assign w_src_pos   = w_launch ? r_pos   : r_snap_pos;

    always_comb begin
        w_ld_num = '0;
        w_ld_den = '0;
        case (w_ld_op)
            OP_WPM: begin
                w_ld_num = 18'(w_src_good) * 18'd120;
                w_ld_den = {1'b0, w_src_times};
            end
            OP_ACC: begin
                w_ld_num = 18'(w_src_good) * 18'd100;
                w_ld_den = w_src_all;
            end
            default: begin
                w_ld_num = 18'(w_src_pos) * 18'd100;
                w_ld_den = {6'd0, r_len};
            end
        endcase
    end

    assign w_ld_num_adj = w_ld_num + (ROUND_EN ? 18'(w_ld_den >> 1) : 18'd0);
    assign w_den_zero   = (w_ld_den == 16'd0);

    // Restoring step: remainder < divisor always, so 16 bits suffice after
    // the conditional subtract.
    assign w_shift  = {r_rem, r_num[17]};
    assign w_ge     = (w_shift >= {1'b0, r_den});
    assign w_rem_nx = w_ge ? (w_shift[15:0] - r_den) : w_shift[15:0];
    assign w_quot   = {r_num[16:0], w_ge};

    assign w_iter_last = r_busy && !r_load && (r_cnt == 5'd17);
    assign w_wr_en     = (w_do_load && w_den_zero) || w_iter_last;
    assign w_wr_op     = w_iter_last ? r_op : w_ld_op;
    assign w_wr_val    = w_iter_last ? w_quot : 18'd0;
    assign w_seq_end   = w_wr_en && (w_wr_op == OP_PCT);

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (start) begin
            w_state_nx = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:  if (r_pos == r_len) w_state_nx = ST_FIN;
                ST_FIN:  if (w_seq_end && r_final) w_state_nx = ST_DONE;
                default: w_state_nx = r_state;
            endcase
        end
    end

    assign running = (r_state == ST_RUN);
    assign done    = (r_state == ST_DONE);

    // ------------------------------------------------- counters and timer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len <= '0; tot <= '0; r_pos <= '0; r_good <= '0; r_all <= '0;
            r_words <= '0; times <= '0; r_presc <= '0; correct <= '0;
        end else if (start) begin
            r_len <= passage_len; tot <= word_count; r_pos <= '0; r_good <= '0;
            r_all <= '0; r_words <= '0; times <= '0; r_presc <= '0; correct <= '0;
        end else begin
            correct <= r_words;
            if (w_key) begin
                if (r_all != 16'hFFFF) r_all <= r_all + 1'b1;
                if (key_correct) begin
                    if (r_good != 16'hFFFF)            r_good  <= r_good + 1'b1;
                    if (r_pos < r_len)                 r_pos   <= r_pos + 1'b1;
                    if (key_space && (r_words < tot))  r_words <= r_words + 1'b1;
                end
            end
            if (w_run) begin
                if (w_tick) begin
                    r_presc <= '0;
                    if (times != 15'h7FFF) times <= times + 1'b1;
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------ recompute sequencer/divider
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pend <= 1'b0; r_busy <= 1'b0; r_load <= 1'b0; r_final <= 1'b0;
            r_op <= OP_WPM; r_cnt <= '0; r_num <= '0; r_rem <= '0; r_den <= '0;
            r_snap_good <= '0; r_snap_all <= '0; r_snap_times <= '0; r_snap_pos <= '0;
            wpm <= '0; acc <= '0; percent <= '0;
        end else if (start) begin
            r_pend <= 1'b0; r_busy <= 1'b0; r_load <= 1'b0; r_final <= 1'b0;
            r_op <= OP_WPM; r_cnt <= '0; r_num <= '0; r_rem <= '0; r_den <= '0;
            wpm <= '0; acc <= '0; percent <= '0;
        end else begin
            r_pend <= w_trig || (r_pend && !w_launch);
            if (w_launch) begin
                r_snap_good  <= r_good;
                r_snap_all   <= r_all;
                r_snap_times <= times;
                r_snap_pos   <= r_pos;
                r_final      <= (r_state == ST_FIN);
            end
            if (w_do_load) begin
                if (w_den_zero) begin
                    // Zero divisor: result forced to 0, skip straight on.
                    r_busy <= (w_ld_op != OP_PCT);
                    r_load <= (w_ld_op != OP_PCT);
                    r_op   <= w_ld_op + 1'b1;
                end else begin
                    r_op   <= w_ld_op;
                    r_num  <= w_ld_num_adj;
                    r_den  <= w_ld_den;
                    r_rem  <= '0;
                    r_cnt  <= '0;
                    r_busy <= 1'b1;
                    r_load <= 1'b0;
                end
            end else if (r_busy) begin
                r_num <= w_quot;
                r_rem <= w_rem_nx;
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == 5'd17) begin
                    r_busy <= (r_op != OP_PCT);
                    r_load <= (r_op != OP_PCT);
                    r_op   <= r_op + 1'b1;
                end
            end
            if (w_wr_en) begin
                case (w_wr_op)
                    OP_WPM:  wpm <= (w_wr_val > 18'(WPM_MAX)) ? 10'(WPM_MAX) : w_wr_val[9:0];
                    OP_ACC:  acc <= w_wr_val[9:0];
                    default: percent <= w_wr_val[9:0];
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_typing_stats.sv
`default_nettype none
// ============================================================================
// Module   : tb_typing_stats
// Purpose  : Directed self-checking bench for typing_stats. Uses a short
//            timer tick (1010 clocks) so multi-tick races stay brief.
//            Expected values are hand-computed from the stats formulas;
//            rounding-dependent values follow STATS_ROUND_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_typing_stats;

    localparam int TICK = 1010;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0, key_valid = 1'b0, key_correct = 1'b0, key_space = 1'b0;
    logic [9:0]  passage_len = '0;
    logic [4:0]  word_count = '0;
    logic [9:0]  percent, wpm, acc;
    logic [4:0]  correct, tot;
    logic [14:0] times;
    logic        running, done;

    int n_pass  = 0;
    int n_total = 0;

    typing_stats #(.CLK_HZ(TICK * 10), .TICK_DIV(TICK), .WPM_MAX(999)) dut (
        .clk(clk), .rst(rst), .start(start), .key_valid(key_valid),
        .key_correct(key_correct), .key_space(key_space),
        .passage_len(passage_len), .word_count(word_count),
        .percent(percent), .wpm(wpm), .acc(acc), .correct(correct), .tot(tot),
        .times(times), .running(running), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // start pulse; optionally with a simultaneous key (must be dropped)
    task automatic start_race(input int len, input int words, input bit with_key);
        @(negedge clk);
        start = 1'b1; passage_len = 10'(len); word_count = 5'(words);
        key_valid = with_key; key_correct = with_key; key_space = with_key;
        @(negedge clk);
        start = 1'b0; key_valid = 1'b0; key_correct = 1'b0; key_space = 1'b0;
    endtask

    task automatic wait_times(input string tag, input int target, input int bound);
        int k = 0;
        while (int'(times) < target && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(tag, int'(times), target);
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k = 0;
        while (!done && k < bound) begin
            @(negedge clk);
            k++;
        end
        check(tag, int'(done), 1);
    endtask

    int exp_acc_rnd, exp_pct_sat;

    initial begin
        // ---------------- reset state
        repeat (3) @(negedge clk);
        check("rst_percent", int'(percent), 0);
        check("rst_wpm", int'(wpm), 0);
        check("rst_acc", int'(acc), 0);
        check("rst_times", int'(times), 0);
        check("rst_running", int'(running), 0);
        rst = 1'b1;

        // ---------------- main race: 20 good / 25 keys, 4 words, 10 ticks
        start_race(50, 10, 1'b0);
        for (int i = 0; i < 25; i++) begin
            key_valid = 1'b1; key_correct = (i < 20); key_space = (i < 4);
            @(negedge clk);
        end
        key_valid = 1'b0; key_correct = 1'b0; key_space = 1'b0;
        wait_times("main_times_wait", 10, 11 * TICK);
        repeat (70) @(negedge clk);
        check("main_times", int'(times), 10);
        check("main_acc", int'(acc), 80);
        check("main_percent", int'(percent), 40);
        check("main_wpm", int'(wpm), 240);
        check("main_correct", int'(correct), 4);
        check("main_tot", int'(tot), 10);
        check("main_running", int'(running), 1);

        // ---------------- asynchronous reset mid-race
        #2 rst = 1'b0;
        #1;
        check("arst_percent", int'(percent), 0);
        check("arst_wpm", int'(wpm), 0);
        check("arst_acc", int'(acc), 0);
        check("arst_times", int'(times), 0);
        check("arst_correct", int'(correct), 0);
        check("arst_tot", int'(tot), 0);
        check("arst_running", int'(running), 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            key_valid = 1'b1; key_correct = 1'b1; key_space = 1'b1;
            @(negedge clk);
        end
        key_valid = 1'b0; key_correct = 1'b0; key_space = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_correct", int'(correct), 0);
        check("idle_times", int'(times), 0);
        check("idle_running", int'(running), 0);

        // ---------------- start+key same cycle, then key on the tick edge
        start_race(50, 10, 1'b1);
        repeat (TICK - 1) @(negedge clk);
        key_valid = 1'b1; key_correct = 1'b1; key_space = 1'b1;
        @(negedge clk);
        key_valid = 1'b0; key_correct = 1'b0; key_space = 1'b0;
        repeat (70) @(negedge clk);
        check("coin_times", int'(times), 1);
        check("coin_acc", int'(acc), 100);
        check("coin_wpm", int'(wpm), 120);
        check("coin_percent", int'(percent), 2);
        check("coin_correct", int'(correct), 1);

        // ---------------- start while a division is in flight
        wait_times("abort_times_wait", 2, 2 * TICK);
        repeat (10) @(negedge clk);
        start_race(50, 10, 1'b0);
        check("abort_wpm_now", int'(wpm), 0);
        check("abort_acc_now", int'(acc), 0);
        check("abort_times_now", int'(times), 0);
        repeat (70) @(negedge clk);
        check("abort_wpm_stale", int'(wpm), 0);
        check("abort_acc_stale", int'(acc), 0);

        // ---------------- tick with no keys
        wait_times("nokey_times_wait", 1, 2 * TICK);
        repeat (70) @(negedge clk);
        check("nokey_wpm", int'(wpm), 0);
        check("nokey_acc", int'(acc), 0);
        check("nokey_percent", int'(percent), 0);

        // ---------------- rounding: 2 good of 3 keys
        start_race(50, 10, 1'b0);
        for (int i = 0; i < 3; i++) begin
            key_valid = 1'b1; key_correct = (i < 2); key_space = 1'b0;
            @(negedge clk);
        end
        key_valid = 1'b0; key_correct = 1'b0;
        wait_times("round_times_wait", 1, 2 * TICK);
        repeat (70) @(negedge clk);
`ifdef STATS_ROUND_EN
        exp_acc_rnd = 67;
        exp_pct_sat = 98;
`else
        exp_acc_rnd = 66;
        exp_pct_sat = 97;
`endif
        check("round_acc", int'(acc), exp_acc_rnd);
        check("round_wpm", int'(wpm), 240);
        check("round_percent", int'(percent), 4);

        // ---------------- wpm saturation: 1000 good keys in 1 tick
        start_race(1023, 31, 1'b0);
        key_valid = 1'b1; key_correct = 1'b1; key_space = 1'b0;
        repeat (1000) @(negedge clk);
        key_valid = 1'b0; key_correct = 1'b0;
        wait_times("sat_times_wait", 1, 2 * TICK);
        repeat (70) @(negedge clk);
        check("sat_wpm", int'(wpm), 999);
        check("sat_acc", int'(acc), 100);
        check("sat_percent", int'(percent), exp_pct_sat);

        // ---------------- full race to completion in 30 ticks
        start_race(50, 10, 1'b0);
        for (int i = 0; i < 49; i++) begin
            key_valid = 1'b1; key_correct = 1'b1; key_space = ((i % 5) == 4);
            @(negedge clk);
        end
        key_valid = 1'b0; key_correct = 1'b0; key_space = 1'b0;
        wait_times("full_times_wait", 30, 31 * TICK);
        repeat (65) @(negedge clk);
        check("full_running_pre", int'(running), 1);
        key_valid = 1'b1; key_correct = 1'b1; key_space = 1'b1;
        @(negedge clk);
        key_valid = 1'b0; key_correct = 1'b0; key_space = 1'b0;
        wait_done("full_done_60", 60);
        check("full_percent", int'(percent), 100);
        check("full_wpm", int'(wpm), 200);
        check("full_acc", int'(acc), 100);
        check("full_correct", int'(correct), 10);
        check("full_running", int'(running), 0);
        repeat (25 * TICK) @(negedge clk);
        check("hold_times", int'(times), 30);
        check("hold_done", int'(done), 1);
        check("hold_percent", int'(percent), 100);

        // ---------------- zero-length passage
        start_race(0, 5, 1'b0);
        wait_done("zero_done", 20);
        check("zero_percent", int'(percent), 0);
        check("zero_tot", int'(tot), 5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
